// File: rtl/rom_stream_reader_if.sv
// Signal bundle between rom_stream_reader and its surroundings: command, ROM port and output stream.
// master is the reader itself; slave is the environment (command source, ROM and stream sink).
interface rom_stream_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  busy;
    logic                  done;
    logic                  rom_ena;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_q;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        input  start, base_addr, length, rom_q, out_ready,
        output busy, done, rom_ena, rom_addr, out_valid, out_data, out_last
    );

    modport slave (
        output start, base_addr, length, rom_q, out_ready,
        input  busy, done, rom_ena, rom_addr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rom_stream_reader.sv
// Reads a run of consecutive ROM words (with address wrap) and forwards them as a valid/ready
// stream with a last marker, hiding the ROM read latency and backpressure behind a 4-entry FIFO.
module rom_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    rom_stream_reader_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [ADDR_WIDTH:0]   remaining;

    logic v1;
    logic v1_last;

    logic [DATA_WIDTH-1:0] fifo_data [4];
    logic                  fifo_last [4];
    logic [1:0]            rd_idx;
    logic [1:0]            wr_idx;
    logic [2:0]            count;

    logic done_r;
    logic done_next;
    logic load;
    logic issue;
    logic final_issue;
    logic push;
    logic pop;

    // A read is only issued if the word it returns is guaranteed a FIFO slot,
    // counting the word already in flight from the previous cycle.
    always_comb begin
        issue       = (state == RUN) && (remaining != '0) &&
                      ((count + {2'b00, v1}) < 3'd4);
        final_issue = issue && (remaining == (ADDR_WIDTH+1)'(1));
        push        = v1;
        pop         = (count != 3'd0) && bus.out_ready;
        load        = (state == IDLE) && bus.start && (bus.length != '0);
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length != '0) begin
                        state_next = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (final_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Finish on the edge that retires the last word so done lines up with busy dropping.
                if (!v1 && ((count == 3'd0) || ((count == 3'd1) && pop))) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            done_r    <= 1'b0;
            ptr       <= '0;
            addr_hold <= '0;
            remaining <= '0;
            v1        <= 1'b0;
            v1_last   <= 1'b0;
        end else begin
            state   <= state_next;
            done_r  <= done_next;
            v1      <= issue;
            v1_last <= final_issue;
            if (load) begin
                ptr       <= bus.base_addr;
                remaining <= bus.length;
            end else if (issue) begin
                ptr       <= ptr + 1'b1;
                remaining <= remaining - 1'b1;
                addr_hold <= ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_data[wr_idx] <= bus.rom_q;
            fifo_last[wr_idx] <= v1_last;
        end
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.done      = done_r;
        bus.rom_ena   = issue;
        bus.rom_addr  = issue ? ptr : addr_hold;
        bus.out_valid = (count != 3'd0);
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        if (count != 3'd0) begin
            bus.out_data = fifo_data[rd_idx];
            bus.out_last = fifo_last[rd_idx];
        end
    end
endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed testbench for rom_stream_reader with a registered ROM model (q = addr + 8'h10).
module tb_rom_stream_reader;
    localparam int DW = 8;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   e0 = 0;

    rom_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    rom_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.rom_ena === 1'b1) bus.rom_q <= bus.rom_addr + 8'h10;
    end

    logic [7:0] beat_data [$];
    logic       beat_last [$];
    int         beat_cyc  [$];
    logic [7:0] ena_addr  [$];
    int         ena_cyc   [$];
    int         done_cyc  [$];
    logic       done_busy [$];

    // Observed traffic, sampled mid-cycle; rel cycle = cyc - e0 + 1 (1 = cycle after the start edge).
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            beat_data.push_back(bus.out_data);
            beat_last.push_back(bus.out_last);
            beat_cyc.push_back(cyc);
        end
        if (bus.rom_ena === 1'b1) begin
            ena_addr.push_back(bus.rom_addr);
            ena_cyc.push_back(cyc);
        end
        if (bus.done === 1'b1) begin
            done_cyc.push_back(cyc);
            done_busy.push_back(bus.busy);
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        beat_data.delete();
        beat_last.delete();
        beat_cyc.delete();
        ena_addr.delete();
        ena_cyc.delete();
        done_cyc.delete();
        done_busy.delete();
    endtask

    task automatic launch(input logic [7:0] b, input logic [8:0] len);
        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.length    = len;
        @(posedge clk);
        #1;
        e0 = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cyc.size() != 0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset;
        logic [20:0] outs;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        tick(3);
        outs = {bus.busy, bus.done, bus.rom_ena, bus.rom_addr, bus.out_valid, bus.out_data, bus.out_last};
        checks++;
        if (outs !== 21'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h exp=%h", outs, 21'h0);
        end
        rst_n = 1'b1;
        tick(2);
        outs = {bus.busy, bus.done, bus.rom_ena, bus.rom_addr, bus.out_valid, bus.out_data, bus.out_last};
        checks++;
        if (outs !== 21'h0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset got=%h exp=%h", outs, 21'h0);
        end
    endtask

    task automatic test_basic;
        bit ok;
        logic [7:0] exp;
        clear_logs();
        bus.out_ready = 1'b1;
        launch(8'h05, 9'd4);
        checks++;
        if ({bus.busy, bus.rom_ena, bus.rom_addr} !== {1'b1, 1'b1, 8'h05}) begin
            failures++;
            $display("[TB] FAIL basic_first_issue got=%b/%b/%h exp=1/1/05", bus.busy, bus.rom_ena, bus.rom_addr);
        end
        wait_done(30, ok);
        tick(3);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_done_timeout got=%0d exp=1", ok);
        end
        checks++;
        if (beat_data.size() !== 4) begin
            failures++;
            $display("[TB] FAIL basic_beat_count got=%0d exp=4", beat_data.size());
        end
        for (int i = 0; i < beat_data.size() && i < 4; i++) begin
            exp = 8'h15 + 8'(i);
            checks++;
            if (beat_data[i] !== exp || beat_last[i] !== (i == 3) || (beat_cyc[i] - e0 + 1) !== 3 + i) begin
                failures++;
                $display("[TB] FAIL basic_beat%0d got=%h/last%b/cyc%0d exp=%h/last%b/cyc%0d",
                         i, beat_data[i], beat_last[i], beat_cyc[i] - e0 + 1, exp, (i == 3), 3 + i);
            end
        end
        checks++;
        if (done_cyc.size() !== 1) begin
            failures++;
            $display("[TB] FAIL basic_done_count got=%0d exp=1", done_cyc.size());
        end else begin
            checks++;
            if ((done_cyc[0] - e0 + 1) !== 7 || done_busy[0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL basic_done_timing got=cyc%0d/busy%b exp=cyc7/busy0",
                         done_cyc[0] - e0 + 1, done_busy[0]);
            end
        end
        checks++;
        if (ena_addr.size() !== 4) begin
            failures++;
            $display("[TB] FAIL basic_issue_count got=%0d exp=4", ena_addr.size());
        end
    endtask

    task automatic test_wrap;
        bit ok;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        clear_logs();
        bus.out_ready = 1'b1;
        launch(8'hFE, 9'd4);
        wait_done(30, ok);
        tick(3);
        checks++;
        if (ok !== 1'b1 || ena_addr.size() !== 4 || beat_data.size() !== 4 || done_cyc.size() !== 1) begin
            failures++;
            $display("[TB] FAIL wrap_counts got=done%0d/ena%0d/beats%0d/dones%0d exp=1/4/4/1",
                     ok, ena_addr.size(), beat_data.size(), done_cyc.size());
        end
        for (int i = 0; i < ena_addr.size() && i < 4; i++) begin
            exp_addr = 8'hFE + 8'(i);
            checks++;
            if (ena_addr[i] !== exp_addr) begin
                failures++;
                $display("[TB] FAIL wrap_addr%0d got=%h exp=%h", i, ena_addr[i], exp_addr);
            end
        end
        for (int i = 0; i < beat_data.size() && i < 4; i++) begin
            exp_data = 8'h0E + 8'(i);
            checks++;
            if (beat_data[i] !== exp_data || beat_last[i] !== (i == 3)) begin
                failures++;
                $display("[TB] FAIL wrap_beat%0d got=%h/last%b exp=%h/last%b",
                         i, beat_data[i], beat_last[i], exp_data, (i == 3));
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int early;
        int stalled;
        int rel;
        int stall_err;
        int data_err;
        int last_err;
        clear_logs();
        ok = 1'b0;
        stall_err = 0;
        bus.out_ready = 1'b1;
        launch(8'h00, 9'd10);
        for (int k = 1; k <= 200; k++) begin
            bus.out_ready = !(k >= 3 && k <= 12);
            if (k >= 3 && k <= 12) begin
                if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10) stall_err++;
            end
            if (done_cyc.size() != 0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        bus.out_ready = 1'b1;
        tick(3);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_done_timeout got=%0d exp=1", ok);
        end
        checks++;
        if (stall_err !== 0) begin
            failures++;
            $display("[TB] FAIL bp_stall_hold got=%0d bad cycles exp=0", stall_err);
        end
        early = 0;
        stalled = 0;
        foreach (ena_cyc[i]) begin
            rel = ena_cyc[i] - e0 + 1;
            if (rel <= 4) early++;
            else if (rel <= 12) stalled++;
        end
        checks++;
        if (early !== 4 || stalled !== 0 || ena_addr.size() !== 10) begin
            failures++;
            $display("[TB] FAIL bp_issue_credit got=early%0d/stalled%0d/total%0d exp=4/0/10",
                     early, stalled, ena_addr.size());
        end
        data_err = 0;
        last_err = 0;
        foreach (beat_data[i]) begin
            if (beat_data[i] !== 8'h10 + 8'(i)) data_err++;
            if (beat_last[i] !== (i == 9)) last_err++;
        end
        checks++;
        if (beat_data.size() !== 10 || data_err !== 0 || last_err !== 0) begin
            failures++;
            $display("[TB] FAIL bp_beats got=n%0d/dataerr%0d/lasterr%0d exp=10/0/0",
                     beat_data.size(), data_err, last_err);
        end
        checks++;
        if (beat_cyc.size() == 0 || (beat_cyc[0] - e0 + 1) !== 13) begin
            failures++;
            $display("[TB] FAIL bp_first_beat_cycle got=%0d exp=13",
                     beat_cyc.size() == 0 ? -1 : beat_cyc[0] - e0 + 1);
        end
        checks++;
        if (done_cyc.size() !== 1) begin
            failures++;
            $display("[TB] FAIL bp_done_count got=%0d exp=1", done_cyc.size());
        end
    endtask

    task automatic test_length_zero;
        bit ok;
        clear_logs();
        bus.out_ready = 1'b1;
        launch(8'h33, 9'd0);
        wait_done(10, ok);
        tick(3);
        checks++;
        if (ok !== 1'b1 || done_cyc.size() !== 1) begin
            failures++;
            $display("[TB] FAIL len0_done got=seen%0d/count%0d exp=1/1", ok, done_cyc.size());
        end else begin
            checks++;
            if ((done_cyc[0] - e0 + 1) !== 1 || done_busy[0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL len0_done_timing got=cyc%0d/busy%b exp=cyc1/busy0",
                         done_cyc[0] - e0 + 1, done_busy[0]);
            end
        end
        checks++;
        if (ena_addr.size() !== 0 || beat_data.size() !== 0) begin
            failures++;
            $display("[TB] FAIL len0_activity got=ena%0d/beats%0d exp=0/0", ena_addr.size(), beat_data.size());
        end
    endtask

    task automatic test_length_full;
        bit ok;
        int data_err;
        int last_err;
        clear_logs();
        bus.out_ready = 1'b1;
        launch(8'h00, 9'd256);
        wait_done(400, ok);
        tick(3);
        checks++;
        if (ok !== 1'b1 || done_cyc.size() !== 1) begin
            failures++;
            $display("[TB] FAIL len256_done got=seen%0d/count%0d exp=1/1", ok, done_cyc.size());
        end else begin
            checks++;
            if ((done_cyc[0] - e0 + 1) !== 259) begin
                failures++;
                $display("[TB] FAIL len256_done_cycle got=%0d exp=259", done_cyc[0] - e0 + 1);
            end
        end
        checks++;
        if (ena_addr.size() !== 256 || ena_addr[ena_addr.size() - 1] !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL len256_issue got=n%0d/lastaddr%h exp=256/ff",
                     ena_addr.size(), ena_addr.size() == 0 ? 8'h00 : ena_addr[ena_addr.size() - 1]);
        end
        data_err = 0;
        last_err = 0;
        foreach (beat_data[i]) begin
            if (beat_data[i] !== 8'(i + 16)) data_err++;
            if (beat_last[i] !== (i == 255)) last_err++;
        end
        checks++;
        if (beat_data.size() !== 256 || data_err !== 0 || last_err !== 0) begin
            failures++;
            $display("[TB] FAIL len256_beats got=n%0d/dataerr%0d/lasterr%0d exp=256/0/0",
                     beat_data.size(), data_err, last_err);
        end
    endtask

    task automatic test_start_while_busy;
        bit ok;
        int data_err;
        int addr_err;
        clear_logs();
        bus.out_ready = 1'b1;
        launch(8'h20, 9'd6);
        tick(1);
        bus.start     = 1'b1;
        bus.base_addr = 8'h50;
        bus.length    = 9'd3;
        tick(1);
        bus.start = 1'b0;
        wait_done(40, ok);
        tick(5);
        data_err = 0;
        foreach (beat_data[i]) begin
            if (beat_data[i] !== 8'h30 + 8'(i) || beat_last[i] !== (i == 5)) data_err++;
        end
        addr_err = 0;
        foreach (ena_addr[i]) begin
            if (ena_addr[i] !== 8'h20 + 8'(i)) addr_err++;
        end
        checks++;
        if (ok !== 1'b1 || beat_data.size() !== 6 || data_err !== 0) begin
            failures++;
            $display("[TB] FAIL busy_start_beats got=done%0d/n%0d/err%0d exp=1/6/0",
                     ok, beat_data.size(), data_err);
        end
        checks++;
        if (ena_addr.size() !== 6 || addr_err !== 0 || done_cyc.size() !== 1 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_start_ignored got=ena%0d/addrerr%0d/dones%0d/busy%b exp=6/0/1/0",
                     ena_addr.size(), addr_err, done_cyc.size(), bus.busy);
        end
    endtask

    task automatic test_random;
        bit ok;
        logic prev_stall;
        logic [7:0] prev_data;
        int hold_err;
        int data_err;
        int last_err;
        clear_logs();
        ok = 1'b0;
        hold_err = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        bus.out_ready = 1'b0;
        launch(8'h80, 9'd256);
        for (int k = 0; k < 4000; k++) begin
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data)) hold_err++;
            bus.out_ready = 1'($urandom_range(0, 1));
            prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
            prev_data  = bus.out_data;
            if (done_cyc.size() != 0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        bus.out_ready = 1'b1;
        tick(3);
        data_err = 0;
        last_err = 0;
        foreach (beat_data[i]) begin
            if (beat_data[i] !== 8'(i + 8'h90)) data_err++;
            if (beat_last[i] !== (i == 255)) last_err++;
        end
        checks++;
        if (ok !== 1'b1 || beat_data.size() !== 256 || data_err !== 0 || last_err !== 0) begin
            failures++;
            $display("[TB] FAIL random_stream got=done%0d/n%0d/dataerr%0d/lasterr%0d exp=1/256/0/0",
                     ok, beat_data.size(), data_err, last_err);
        end
        checks++;
        if (hold_err !== 0 || done_cyc.size() !== 1) begin
            failures++;
            $display("[TB] FAIL random_hold got=holderr%0d/dones%0d exp=0/1", hold_err, done_cyc.size());
        end
    endtask

    task automatic test_reset_mid_run;
        bit ok;
        logic [20:0] outs;
        clear_logs();
        bus.out_ready = 1'b1;
        launch(8'h00, 9'd10);
        for (int i = 0; i < 20; i++) begin
            if (beat_data.size() >= 3) break;
            tick(1);
        end
        checks++;
        if (beat_data.size() !== 3) begin
            failures++;
            $display("[TB] FAIL midrst_pre_beats got=%0d exp=3", beat_data.size());
        end
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        tick(1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        outs = {bus.busy, bus.done, bus.rom_ena, bus.rom_addr, bus.out_valid, bus.out_data, bus.out_last};
        checks++;
        if (outs !== 21'h0) begin
            failures++;
            $display("[TB] FAIL midrst_outputs got=%h exp=%h", outs, 21'h0);
        end
        checks++;
        if (done_cyc.size() !== 0) begin
            failures++;
            $display("[TB] FAIL midrst_early_done got=%0d exp=0", done_cyc.size());
        end
        clear_logs();
        tick(20);
        checks++;
        if (beat_data.size() !== 0 || done_cyc.size() !== 0 || ena_addr.size() !== 0) begin
            failures++;
            $display("[TB] FAIL midrst_quiet got=beats%0d/dones%0d/ena%0d exp=0/0/0",
                     beat_data.size(), done_cyc.size(), ena_addr.size());
        end
        clear_logs();
        launch(8'h40, 9'd2);
        wait_done(30, ok);
        tick(3);
        checks++;
        if (ok !== 1'b1 || beat_data.size() !== 2 || done_cyc.size() !== 1) begin
            failures++;
            $display("[TB] FAIL midrst_rerun_counts got=done%0d/beats%0d/dones%0d exp=1/2/1",
                     ok, beat_data.size(), done_cyc.size());
        end else begin
            checks++;
            if ({beat_data[0], beat_last[0], beat_data[1], beat_last[1]} !== {8'h50, 1'b0, 8'h51, 1'b1}) begin
                failures++;
                $display("[TB] FAIL midrst_rerun_data got=%h/%b %h/%b exp=50/0 51/1",
                         beat_data[0], beat_last[0], beat_data[1], beat_last[1]);
            end
        end
    endtask

    initial begin
        $display("[TB] starting rom_stream_reader bench");
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_length_zero();
        test_length_full();
        test_start_while_busy();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
